osd_wr_ctrl: RTL and testbench

- Sequencer and arbiter for the OSD character/pixel buffer write port, clocked on clk_sys.
- Decodes the io-controller OSD command stream, already deserialized into bytes: enable/disable and line write.
- Shares the single buffer write port with a core-side requester, e.g. a status/message writer.
- Owns the osd_enable flag driven into the OSD overlay.

---
 rtl/osd_wr_ctrl.sv | 147 ++++++++++++++
 tb/tb_osd_wr_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/osd_wr_ctrl.sv
// OSD buffer write sequencer: decodes the io-controller command stream and shares
// the buffer write port with a core requester. Optional auto-hide: OSD_AUTOHIDE_EN.
module osd_wr_ctrl #(
  parameter int AW          = 11,
  parameter int HIDE_FRAMES = 600
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          spi_start,
  input  logic          spi_end,
  input  logic          spi_valid,
  input  logic [7:0]    spi_byte,
  input  logic          core_req,
  input  logic [AW-1:0] core_addr,
  input  logic [7:0]    core_data,
  output logic          core_ack,
  input  logic          frame_tick,
  output logic          buf_we,
  output logic [AW-1:0] buf_addr,
  output logic [7:0]    buf_din,
  output logic          osd_enable,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, CMD, WRITE, DROP} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          buf_we_q, buf_we_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d;
  logic [7:0]    buf_din_q, buf_din_d;
  logic          core_ack_q, core_ack_d;
  logic          osd_enable_q, osd_enable_d;
  logic          busy_q, busy_d;
  logic          spi_wr, cmd_en;

`ifdef OSD_AUTOHIDE_EN
  localparam int FW = $clog2(HIDE_FRAMES + 1);
  logic [FW-1:0] fcnt_q, fcnt_d;
`else
  logic unused_ok;
  assign unused_ok = frame_tick ^ (HIDE_FRAMES == 0);
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    buf_we_d     = 1'b0;
    buf_addr_d   = buf_addr_q;
    buf_din_d    = buf_din_q;
    core_ack_d   = 1'b0;
    osd_enable_d = osd_enable_q;
    busy_d       = busy_q;
    spi_wr       = 1'b0;
    cmd_en       = 1'b0;

    if (spi_start) begin
      state_d = CMD;
      busy_d  = 1'b1;
    end else begin
      if (spi_valid) begin
        case (state_q)
          CMD: begin
            if (spi_byte[7:3] == 5'b01000) begin
              osd_enable_d = spi_byte[0];
              cmd_en       = 1'b1;
              state_d      = DROP;
            end else if (spi_byte[7:3] == 5'b00100) begin
              cnt_d   = AW'({spi_byte[2:0], 8'h00});
              state_d = WRITE;
            end else begin
              state_d = DROP;
            end
          end
          WRITE: begin
            spi_wr     = 1'b1;
            buf_we_d   = 1'b1;
            buf_addr_d = cnt_q;
            buf_din_d  = spi_byte;
            cnt_d      = cnt_q + AW'(1);
          end
          default: ;
        endcase
      end
      if (spi_end) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    end

    // During the ack cycle core_req still carries the request just served, so
    // a grant there would write it twice; the requester updates it one cycle later.
    if (!spi_wr && core_req && !core_ack_q) begin
      buf_we_d   = 1'b1;
      buf_addr_d = core_addr;
      buf_din_d  = core_data;
      core_ack_d = 1'b1;
    end

`ifdef OSD_AUTOHIDE_EN
    fcnt_d = fcnt_q;
    if (frame_tick && osd_enable_q && fcnt_q != FW'(HIDE_FRAMES))
      fcnt_d = fcnt_q + FW'(1);
    if (osd_enable_q && fcnt_q == FW'(HIDE_FRAMES) && !cmd_en)
      osd_enable_d = 1'b0;
    // An enable command restarts the timeout even when the flag is already set.
    if (spi_start || cmd_en || (osd_enable_d != osd_enable_q))
      fcnt_d = '0;
`endif
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      buf_we_q     <= 1'b0;
      buf_addr_q   <= '0;
      buf_din_q    <= '0;
      core_ack_q   <= 1'b0;
      osd_enable_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef OSD_AUTOHIDE_EN
      fcnt_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      buf_we_q     <= buf_we_d;
      buf_addr_q   <= buf_addr_d;
      buf_din_q    <= buf_din_d;
      core_ack_q   <= core_ack_d;
      osd_enable_q <= osd_enable_d;
      busy_q       <= busy_d;
`ifdef OSD_AUTOHIDE_EN
      fcnt_q       <= fcnt_d;
`endif
    end
  end

  assign buf_we     = buf_we_q;
  assign buf_addr   = buf_addr_q;
  assign buf_din    = buf_din_q;
  assign core_ack   = core_ack_q;
  assign osd_enable = osd_enable_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_osd_wr_ctrl.sv
// Directed + randomized bench for osd_wr_ctrl; expected writes come from line/offset
// arithmetic over the command stream, not from the controller's state machine.
module tb_osd_wr_ctrl;
`ifdef OSD_AUTOHIDE_EN
  localparam int HF = 3;
`else
  localparam int HF = 600;
`endif
  localparam int AW = 11;

  logic          clk_sys = 1'b0;
  logic          rst;
  logic          spi_start, spi_end, spi_valid;
  logic [7:0]    spi_byte;
  logic          core_req;
  logic [AW-1:0] core_addr;
  logic [7:0]    core_data;
  logic          core_ack;
  logic          frame_tick;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_din;
  logic          osd_enable;
  logic          busy;

  int passed = 0;
  int total  = 0;

  osd_wr_ctrl #(.AW(AW), .HIDE_FRAMES(HF)) dut (
    .clk_sys(clk_sys), .rst(rst),
    .spi_start(spi_start), .spi_end(spi_end), .spi_valid(spi_valid), .spi_byte(spi_byte),
    .core_req(core_req), .core_addr(core_addr), .core_data(core_data), .core_ack(core_ack),
    .frame_tick(frame_tick),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_din(buf_din),
    .osd_enable(osd_enable), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic start();
    spi_start = 1'b1; cyc(); spi_start = 1'b0;
  endtask

  task automatic fin();
    spi_end = 1'b1; cyc(); spi_end = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    spi_valid = 1'b1; spi_byte = b; cyc(); spi_valid = 1'b0;
  endtask

  // Expected write: strobe plus address/data; no write means strobe low only.
  task automatic chk_wr(input string tag, input bit we, input int a, input int d);
    chk({tag, "_we"}, buf_we, we);
    if (we) begin
      chk({tag, "_addr"}, buf_addr, a);
      chk({tag, "_din"}, buf_din, d);
    end
  endtask

  initial begin
    int ptr, line, n, a;
    logic [7:0] b;
    rst = 1'b1; spi_start = 0; spi_end = 0; spi_valid = 0; spi_byte = 0;
    core_req = 0; core_addr = 0; core_data = 0; frame_tick = 0;
    cyc(); cyc();
    chk("reset_outs", {buf_we, core_ack, osd_enable, busy, 3'b0, buf_addr, buf_din}, 0);
    rst = 1'b0;
    cyc();

    // enable/disable commands and busy window
    start();
    chk("busy_open", busy, 1);
    send(8'h41);
    chk("en_on", osd_enable, 1);
    chk("en_no_we", buf_we, 0);
    fin();
    chk("busy_closed", busy, 0);
    start(); send(8'h40);
    chk("en_off", osd_enable, 0);
    fin();

    // line 3 write
    start(); send(8'h23);
    chk_wr("cmd_no_we", 0, 0, 0);
    send(8'hAA); chk_wr("l3b0", 1, 12'h300, 8'hAA);
    cyc();       chk_wr("l3gap", 0, 0, 0);
    send(8'h55); chk_wr("l3b1", 1, 12'h301, 8'h55);
    fin();

    // line 7, 257 bytes: last one wraps to address 0
    start(); send(8'h27);
    for (int i = 0; i < 257; i++) begin
      b = 8'($urandom);
      send(b);
      chk_wr("wrap", 1, (12'h700 + i) % 2048, b);
    end
    fin();

    // unknown command drops the frame
    start(); send(8'h80);
    for (int i = 0; i < 5; i++) begin
      send(8'($urandom));
      chk_wr("drop", 0, 0, 0);
    end
    fin();

    // randomized line writes with random gaps
    for (int f = 0; f < 8; f++) begin
      line = $urandom_range(0, 7);
      n    = $urandom_range(1, 12);
      ptr  = line * 256;
      start(); send({5'b00100, line[2:0]});
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        send(b);
        chk_wr("rnd", 1, ptr % 2048, b);
        ptr++;
        if ($urandom_range(0, 2) == 0) begin
          cyc(); chk_wr("rnd_gap", 0, 0, 0);
        end
      end
      fin();
    end

    // spi_start inside WRITE restarts at command decode
    start(); send(8'h21); send(8'h01);
    start(); send(8'h41);
    chk("restart_en", osd_enable, 1);
    chk("restart_no_we", buf_we, 0);
    fin();
    // start and end together: start wins
    spi_start = 1'b1; spi_end = 1'b1; cyc(); spi_start = 1'b0; spi_end = 1'b0;
    chk("start_wins_busy", busy, 1);
    send(8'h40);
    chk("start_wins_cmd", osd_enable, 0);
    fin();

    // core write contended by an SPI data byte
    start(); send(8'h25);
    b = 8'($urandom);
    spi_valid = 1'b1; spi_byte = b;
    core_req = 1'b1; core_addr = 11'h123; core_data = 8'h5A;
    cyc(); spi_valid = 1'b0;
    chk_wr("cont_spi", 1, 12'h500, b);
    chk("cont_no_ack", core_ack, 0);
    cyc();
    chk_wr("cont_core", 1, 12'h123, 8'h5A);
    chk("cont_ack", core_ack, 1);
    core_req = 1'b0;
    cyc();
    chk_wr("cont_idle", 0, 0, 0);
    chk("cont_ack_drop", core_ack, 0);
    fin();

    // uncontended core writes: ack after one cycle
    for (int i = 0; i < 6; i++) begin
      a = $urandom_range(0, 2047);
      b = 8'($urandom);
      core_req = 1'b1; core_addr = a[AW-1:0]; core_data = b;
      cyc();
      chk("core_ack", core_ack, 1);
      chk_wr("core_wr", 1, a, b);
      core_req = 1'b0;
      cyc();
      chk("core_ack_pulse", core_ack, 0);
      chk_wr("core_idle", 0, 0, 0);
    end

    // async reset mid-WRITE frame
    start(); send(8'h41); fin();
    start(); send(8'h23); send(8'h11);
    chk_wr("pre_rst", 1, 12'h300, 8'h11);
    rst = 1'b1; #2;
    chk("rst_async", {buf_we, core_ack, osd_enable, busy, 3'b0, buf_addr, buf_din}, 0);
    rst = 1'b0;
    send(8'h99);
    chk_wr("post_rst_byte", 0, 0, 0);
    chk("post_rst_busy", busy, 0);

`ifdef OSD_AUTOHIDE_EN
    start(); send(8'h41); fin();
    repeat (3) begin frame_tick = 1'b1; cyc(); frame_tick = 1'b0; end
    chk("hide_pending", osd_enable, 1);
    cyc();
    chk("hide_expired", osd_enable, 0);
    start(); send(8'h41); fin();
    repeat (2) begin frame_tick = 1'b1; cyc(); frame_tick = 1'b0; end
    start(); fin();
    repeat (2) begin frame_tick = 1'b1; cyc(); frame_tick = 1'b0; end
    cyc(); cyc();
    chk("hide_restarted", osd_enable, 1);
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    cyc();
    chk("hide_after_restart", osd_enable, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
